// File: rtl/dsss_despreader.sv
// DSSS despreader: majority-votes chip^pn over each 15-chip PN period to recover one data bit.
// Optional lock detector compiled in when LOCK_DET_EN is defined; otherwise lock is tied low.
module dsss_despreader #(
  parameter int SEQ_LEN     = 15,
  parameter int CNT_W       = 4,
`ifdef LOCK_DET_EN
  parameter int LOCK_MARGIN = 11,
  parameter int LOCK_BITS   = 4,
`endif
  parameter int ACC_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             chip_valid,
  input  logic             chip_in,
  input  logic             pn_in,
  input  logic             sync,
  output logic             data_out,
  output logic             data_valid,
  output logic [ACC_W-1:0] corr_out,
  output logic             sync_err,
  output logic             lock
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);
  localparam logic [ACC_W-1:0] HALF     = ACC_W'(SEQ_LEN / 2);

  state_t           state_p0, state_nxt;
  logic [CNT_W-1:0] idx_p0, idx_nxt;
  logic [ACC_W-1:0] acc_p0, acc_nxt, acc_sum, corr_nxt;
  logic             agree, dout_nxt, vld_nxt, serr_nxt;

  // SEQ_LEN is odd, so a strict majority always exists.
  function automatic logic majority(input logic [ACC_W-1:0] ones);
    return ones > HALF;
  endfunction

  always_comb begin
    state_nxt = state_p0;
    idx_nxt   = idx_p0;
    acc_nxt   = acc_p0;
    dout_nxt  = data_out;
    corr_nxt  = corr_out;
    vld_nxt   = 1'b0;
    serr_nxt  = 1'b0;
    agree     = chip_in ^ pn_in;
    acc_sum   = acc_p0 + ACC_W'(agree);
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      acc_nxt   = '0;
    end else if (chip_valid) begin
      case (state_p0)
        IDLE: begin
          if (sync) begin
            state_nxt = ACCUM;
            idx_nxt   = CNT_W'(1);
            acc_nxt   = ACC_W'(agree);
          end
        end
        default: begin
          if (sync && idx_p0 != '0) begin
            // Realignment: drop the partial bit and treat this chip as chip 0.
            serr_nxt = 1'b1;
            idx_nxt  = CNT_W'(1);
            acc_nxt  = ACC_W'(agree);
          end else if (idx_p0 == LAST_IDX) begin
            vld_nxt  = 1'b1;
            dout_nxt = majority(acc_sum);
            corr_nxt = acc_sum;
            idx_nxt  = '0;
            acc_nxt  = '0;
          end else begin
            idx_nxt = idx_p0 + 1'b1;
            acc_nxt = acc_sum;
          end
        end
      endcase
    end
  end

  // Stage p0 -> output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      idx_p0     <= '0;
      acc_p0     <= '0;
      data_out   <= 1'b0;
      corr_out   <= '0;
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      idx_p0     <= idx_nxt;
      acc_p0     <= acc_nxt;
      data_out   <= dout_nxt;
      corr_out   <= corr_nxt;
      data_valid <= vld_nxt;
      sync_err   <= serr_nxt;
    end
  end

`ifdef LOCK_DET_EN
  localparam int LCNT_W = $clog2(LOCK_BITS + 1);

  logic [LCNT_W-1:0] strong_cnt;

  function automatic logic is_strong(input logic [ACC_W-1:0] ones);
    int signed dist;
    dist = 2 * int'(ones) - SEQ_LEN;
    if (dist < 0) dist = -dist;
    return dist >= LOCK_MARGIN;
  endfunction

  // Lock follows the registered bit report, so it lags data_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst || !en || sync_err) begin
      strong_cnt <= '0;
      lock       <= 1'b0;
    end else if (data_valid) begin
      if (is_strong(corr_out)) begin
        if (int'(strong_cnt) < LOCK_BITS) strong_cnt <= strong_cnt + 1'b1;
        lock <= (int'(strong_cnt) + 1 >= LOCK_BITS);
      end else begin
        strong_cnt <= '0;
        lock       <= 1'b0;
      end
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule
